// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM arbiter slice.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 22;
    localparam int SDRAM_DATA_W = 16;

    localparam logic PORT_ADC  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ERROR_RECOVER
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// Grant selector: port 0 priority, with an optional starvation guard
// for port 1 when SDRAM_ARB_STARVE_GUARD_EN is defined.
module sdram_arb_prio
    import sdram_pkg::*;
#(
    parameter int MAX_STARVE = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic p0_req,
    input  logic p1_req,
    input  logic grant,
    output logic winner
);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_STARVE + 1);

    logic [CW-1:0] starve;
    logic          force_host;

    assign force_host = p1_req && (starve == CW'(MAX_STARVE));
    assign winner     = (!p0_req || force_host) ? PORT_HOST : PORT_ADC;

    // Never exceeds MAX_STARVE: at the limit port 1 wins and clears it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            starve <= '0;
        end else if (grant) begin
            if (winner == PORT_HOST)
                starve <= '0;
            else if (p1_req)
                starve <= starve + 1'b1;
        end
    end
`else
    logic unused_prio;

    assign winner      = p0_req ? PORT_ADC : PORT_HOST;
    assign unused_prio = ^{Clk, Reset_n, grant, p1_req, (MAX_STARVE > 0)};
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller transaction port.
// Optional port-1 starvation guard: SDRAM_ARB_STARVE_GUARD_EN.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W      = SDRAM_ADDR_W,
    parameter int DATA_W      = SDRAM_DATA_W,
    parameter int ACK_TIMEOUT = 1024,
    parameter int MAX_STARVE  = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              P0_Req,
    input  logic              P0_WnR,
    input  logic [ADDR_W-1:0] P0_Address,
    input  logic [DATA_W-1:0] P0_DataIn,
    output logic              P0_Ack,
    output logic              P0_Done,
    output logic [DATA_W-1:0] P0_DataOut,
    input  logic              P1_Req,
    input  logic              P1_WnR,
    input  logic [ADDR_W-1:0] P1_Address,
    input  logic [DATA_W-1:0] P1_DataIn,
    output logic              P1_Ack,
    output logic              P1_Done,
    output logic [DATA_W-1:0] P1_DataOut,
    output logic              Mem_Req,
    output logic              Mem_WnR,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_DataIn,
    input  logic [DATA_W-1:0] Mem_DataOut,
    input  logic              Mem_Busy,
    input  logic              Mem_Ack,
    output logic              Err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    arb_state_t    state;
    logic          owner;
    logic          win;
    logic          grant;
    logic [TW-1:0] tmo;

    assign grant = (state == IDLE) && !Mem_Busy && (P0_Req || P1_Req);

    sdram_arb_prio #(
        .MAX_STARVE(MAX_STARVE)
    ) u_prio (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .p0_req (P0_Req),
        .p1_req (P1_Req),
        .grant  (grant),
        .winner (win)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            owner       <= PORT_ADC;
            tmo         <= '0;
            P0_Ack      <= 1'b0;
            P1_Ack      <= 1'b0;
            P0_Done     <= 1'b0;
            P1_Done     <= 1'b0;
            P0_DataOut  <= '0;
            P1_DataOut  <= '0;
            Mem_Req     <= 1'b0;
            Mem_WnR     <= 1'b0;
            Mem_Address <= '0;
            Mem_DataIn  <= '0;
            Err         <= 1'b0;
        end else begin
            P0_Ack  <= 1'b0;
            P1_Ack  <= 1'b0;
            P0_Done <= 1'b0;
            P1_Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner       <= win;
                        Mem_Req     <= 1'b1;
                        Mem_WnR     <= win ? P1_WnR : P0_WnR;
                        Mem_Address <= win ? P1_Address : P0_Address;
                        Mem_DataIn  <= win ? P1_DataIn : P0_DataIn;
                        tmo         <= TW'(ACK_TIMEOUT);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (Mem_Ack) begin
                        Mem_Req <= 1'b0;
                        P0_Ack  <= (owner == PORT_ADC);
                        P1_Ack  <= (owner == PORT_HOST);
                        state   <= WAIT_DONE;
                    end else if (tmo <= TW'(1)) begin
                        Err     <= 1'b1;
                        Mem_Req <= 1'b0;
                        state   <= ERROR_RECOVER;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!Mem_Busy && !Mem_Ack) begin
                        P0_Done <= (owner == PORT_ADC);
                        P1_Done <= (owner == PORT_HOST);
                        if (!Mem_WnR && owner == PORT_ADC)
                            P0_DataOut <= Mem_DataOut;
                        if (!Mem_WnR && owner == PORT_HOST)
                            P1_DataOut <= Mem_DataOut;
                        state <= IDLE;
                    end
                end
                ERROR_RECOVER: begin
                    // Completes the aborted command so the requester is released.
                    if (!Mem_Busy) begin
                        P0_Done <= (owner == PORT_ADC);
                        P1_Done <= (owner == PORT_HOST);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
